stage3_ex: RTL and testbench

STAGE3_EX -- requirements
Module: stage3_EX

---
 rtl/stage3_ex_pkg.sv | 59 +++++
 rtl/stage3_ex_if.sv | 29 ++
 rtl/stage3_ex_div_iter.sv | 88 ++++++++
 rtl/stage3_ex.sv | 102 ++++++++++
 tb/tb_stage3_ex.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/stage3_ex_pkg.sv
// Shared pipeline definitions for the EX stage: bus widths, bus layouts,
// ALU one-hot bit positions and divider operation encodings.
package stage3_ex_pkg;

  localparam int WIDTH_DS_TO_ES_BUS = 150;
  localparam int WIDTH_ES_TO_MS_BUS = 71;
  localparam int WIDTH_ES_TO_DS_BUS = 6;

  // alu_op one-hot bit indices
  localparam int ALU_OP_W = 12;
  localparam int ALU_ADD  = 0;
  localparam int ALU_SUB  = 1;
  localparam int ALU_SLT  = 2;
  localparam int ALU_SLTU = 3;
  localparam int ALU_AND  = 4;
  localparam int ALU_NOR  = 5;
  localparam int ALU_OR   = 6;
  localparam int ALU_XOR  = 7;
  localparam int ALU_SLL  = 8;
  localparam int ALU_SRL  = 9;
  localparam int ALU_SRA  = 10;
  localparam int ALU_LUI  = 11;

  // div_op encodings
  localparam logic [1:0] DIV_NONE = 2'b00;
  localparam logic [1:0] DIV_SQ   = 2'b01;  // signed quotient
  localparam logic [1:0] DIV_SR   = 2'b10;  // signed remainder
  localparam logic [1:0] DIV_UQ   = 2'b11;  // unsigned quotient

  // Decode -> EX bus; first member lands in the MSBs
  typedef struct packed {
    logic [1:0]          div_op;
    logic [4:0]          dest;
    logic                res_from_mem;
    logic                mem_we;
    logic                gr_we;
    logic [ALU_OP_W-1:0] alu_op;
    logic [31:0]         rkd_value;
    logic [31:0]         alu_src2;
    logic [31:0]         alu_src1;
    logic [31:0]         pc;
  } ds_to_es_t;

  // EX -> MEM bus
  typedef struct packed {
    logic [31:0] result;
    logic [4:0]  dest;
    logic        res_from_mem;
    logic        gr_we;
    logic [31:0] pc;
  } es_to_ms_t;

  // Magnitude of a two's-complement word (0x80000000 maps to itself,
  // which is the correct unsigned magnitude)
  function automatic logic [31:0] abs32(input logic [31:0] v);
    return v[31] ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/stage3_ex_if.sv
// Handshake and bus bundle around the EX stage. The slave side is the EX
// stage itself; the master side is its surrounding pipeline.
interface stage3_ex_if import stage3_ex_pkg::*; ();

  logic                          ds_to_es_valid;
  logic                          es_allow_in;
  logic [WIDTH_DS_TO_ES_BUS-1:0] ds_to_es_bus;
  logic                          ms_allow_in;
  logic                          es_to_ms_valid;
  logic [WIDTH_ES_TO_MS_BUS-1:0] es_to_ms_bus;
  logic [WIDTH_ES_TO_DS_BUS-1:0] es_to_ds_bus;
  logic                          data_sram_en;
  logic [3:0]                    data_sram_we;
  logic [31:0]                   data_sram_addr;
  logic [31:0]                   data_sram_wdata;

  modport master (
    output ds_to_es_valid, ds_to_es_bus, ms_allow_in,
    input  es_allow_in, es_to_ms_valid, es_to_ms_bus, es_to_ds_bus,
           data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata
  );

  modport slave (
    input  ds_to_es_valid, ds_to_es_bus, ms_allow_in,
    output es_allow_in, es_to_ms_valid, es_to_ms_bus, es_to_ds_bus,
           data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata
  );

endinterface

// File: rtl/stage3_ex_div_iter.sv
// Iterative 32-bit restoring divider: one capture cycle, 32 step cycles,
// then holds the fixed-up result in DONE until the consumer acknowledges.
module div_iter import stage3_ex_pkg::*; (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic        is_signed,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  output logic        busy,
  output logic        done,
  input  logic        ack,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]  state_reg, state_next;
  logic [4:0]  cnt_reg;
  logic [31:0] divisor_reg;
  logic [31:0] quo_reg;      // dividend bits shift out the top, quotient bits in at the bottom
  logic [31:0] rem_reg;
  logic        neg_q_reg, neg_r_reg, div_zero_reg;
  logic [32:0] trial, diff;

  // One restoring step: bring in the next dividend bit and try to subtract
  always_comb begin
    trial = {rem_reg, quo_reg[31]};
    diff  = trial - {1'b0, divisor_reg};
  end

  // Next-state logic for IDLE -> BUSY -> DONE -> IDLE
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (start) state_next = S_BUSY;
      S_BUSY:  if (cnt_reg == 5'd31) state_next = S_DONE;
      S_DONE:  if (ack) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // State, counter and datapath registers; reset aborts any division in flight
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg    <= S_IDLE;
      cnt_reg      <= '0;
      divisor_reg  <= '0;
      quo_reg      <= '0;
      rem_reg      <= '0;
      neg_q_reg    <= 1'b0;
      neg_r_reg    <= 1'b0;
      div_zero_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (state_reg == S_IDLE && start) begin
        cnt_reg      <= '0;
        rem_reg      <= '0;
        quo_reg      <= is_signed ? abs32(src1) : src1;
        divisor_reg  <= is_signed ? abs32(src2) : src2;
        neg_q_reg    <= is_signed && (src1[31] ^ src2[31]);
        neg_r_reg    <= is_signed && src1[31];
        div_zero_reg <= (src2 == 32'd0);
      end else if (state_reg == S_BUSY) begin
        cnt_reg <= cnt_reg + 5'd1;
        if (!diff[32]) begin
          rem_reg <= diff[31:0];
          quo_reg <= {quo_reg[30:0], 1'b1};
        end else begin
          rem_reg <= trial[31:0];
          quo_reg <= {quo_reg[30:0], 1'b0};
        end
      end
    end
  end

  // Sign fix-up; divide by zero reports all-ones quotient and remainder = src1
  always_comb begin
    busy      = (state_reg == S_BUSY);
    done      = (state_reg == S_DONE);
    quotient  = div_zero_reg ? 32'hFFFF_FFFF : (neg_q_reg ? (~quo_reg + 32'd1) : quo_reg);
    remainder = neg_r_reg ? (~rem_reg + 32'd1) : rem_reg;
  end

endmodule

// File: rtl/stage3_ex.sv
// EX pipeline stage: latches the decoded instruction, runs the ALU or the
// iterative divider, issues the data SRAM request and forwards to MEM.
module stage3_ex import stage3_ex_pkg::*; (
  input logic         clk,
  input logic         resetn,
  stage3_ex_if.slave  bus_if
);

  ds_to_es_t   es_bus_reg;
  es_to_ms_t   ms_bus;
  logic        es_valid_reg;
  logic        es_ready_go;
  logic        es_allow_in;
  logic        es_to_ms_valid;
  logic [31:0] alu_a, alu_b, alu_result, es_result;
  logic [31:0] add_res, sub_res;
  logic [4:0]  shamt;
  logic        div_start, div_busy, div_done, div_ack;
  logic [31:0] div_quotient, div_remainder;

  // Stage valid: refilled from decode whenever EX can accept
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)          es_valid_reg <= 1'b0;
    else if (es_allow_in) es_valid_reg <= bus_if.ds_to_es_valid;
  end

  // Instruction register: captured on a decode handshake, held otherwise
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                                   es_bus_reg <= '0;
    else if (bus_if.ds_to_es_valid && es_allow_in) es_bus_reg <= bus_if.ds_to_es_bus;
  end

  // ALU: one-hot op select, each term masked by its op bit
  always_comb begin
    alu_a   = es_bus_reg.alu_src1;
    alu_b   = es_bus_reg.alu_src2;
    shamt   = alu_b[4:0];
    add_res = alu_a + alu_b;
    sub_res = alu_a - alu_b;
    alu_result =
        ({32{es_bus_reg.alu_op[ALU_ADD]}}  & add_res)
      | ({32{es_bus_reg.alu_op[ALU_SUB]}}  & sub_res)
      | ({32{es_bus_reg.alu_op[ALU_SLT]}}  & {31'd0, $signed(alu_a) < $signed(alu_b)})
      | ({32{es_bus_reg.alu_op[ALU_SLTU]}} & {31'd0, alu_a < alu_b})
      | ({32{es_bus_reg.alu_op[ALU_AND]}}  & (alu_a & alu_b))
      | ({32{es_bus_reg.alu_op[ALU_NOR]}}  & ~(alu_a | alu_b))
      | ({32{es_bus_reg.alu_op[ALU_OR]}}   & (alu_a | alu_b))
      | ({32{es_bus_reg.alu_op[ALU_XOR]}}  & (alu_a ^ alu_b))
      | ({32{es_bus_reg.alu_op[ALU_SLL]}}  & (alu_a << shamt))
      | ({32{es_bus_reg.alu_op[ALU_SRL]}}  & (alu_a >> shamt))
      | ({32{es_bus_reg.alu_op[ALU_SRA]}}  & 32'($signed(alu_a) >>> shamt))
      | ({32{es_bus_reg.alu_op[ALU_LUI]}}  & alu_b);
  end

  assign div_start = es_valid_reg && (es_bus_reg.div_op != DIV_NONE);
  assign div_ack   = es_to_ms_valid && bus_if.ms_allow_in;

  div_iter u_div_iter (
    .clk       (clk),
    .resetn    (resetn),
    .start     (div_start),
    .is_signed (es_bus_reg.div_op != DIV_UQ),
    .src1      (es_bus_reg.alu_src1),
    .src2      (es_bus_reg.alu_src2),
    .busy      (div_busy),
    .done      (div_done),
    .ack       (div_ack),
    .quotient  (div_quotient),
    .remainder (div_remainder)
  );

  // Handshake, result select and outgoing buses
  always_comb begin
    es_ready_go    = (es_bus_reg.div_op == DIV_NONE) || (div_done && !div_busy);
    es_allow_in    = !es_valid_reg || (es_ready_go && bus_if.ms_allow_in);
    es_to_ms_valid = es_valid_reg && es_ready_go;

    es_result = alu_result;
    if (es_bus_reg.div_op == DIV_SR)        es_result = div_remainder;
    else if (es_bus_reg.div_op != DIV_NONE) es_result = div_quotient;

    ms_bus.result       = es_result;
    ms_bus.dest         = es_bus_reg.dest;
    ms_bus.res_from_mem = es_bus_reg.res_from_mem;
    ms_bus.gr_we        = es_bus_reg.gr_we;
    ms_bus.pc           = es_bus_reg.pc;
  end

  assign bus_if.es_allow_in    = es_allow_in;
  assign bus_if.es_to_ms_valid = es_to_ms_valid;
  assign bus_if.es_to_ms_bus   = ms_bus;
  assign bus_if.es_to_ds_bus   = {es_bus_reg.gr_we & es_valid_reg, es_bus_reg.dest};

  // The SRAM request fires only in the cycle the instruction moves on, so a
  // stalled memory op issues exactly once
  assign bus_if.data_sram_en    = es_valid_reg && es_ready_go && bus_if.ms_allow_in
                                  && (es_bus_reg.mem_we || es_bus_reg.res_from_mem);
  assign bus_if.data_sram_we    = {4{bus_if.data_sram_en && es_bus_reg.mem_we}};
  assign bus_if.data_sram_addr  = alu_result;
  assign bus_if.data_sram_wdata = es_bus_reg.rkd_value;

endmodule

// File: tb/tb_stage3_ex.sv
// Directed testbench for the EX stage: ALU ops, divider results/latency,
// store backpressure and reset in the middle of a divide.
module tb_stage3_ex;
  import stage3_ex_pkg::*;

  logic clk = 1'b0;
  logic resetn;
  int   checks = 0;
  int   errors = 0;

  stage3_ex_if bus_if();

  stage3_ex dut (
    .clk    (clk),
    .resetn (resetn),
    .bus_if (bus_if.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [149:0] mk(input logic [11:0] op, input logic [31:0] s1,
                                      input logic [31:0] s2, input logic [1:0] dop,
                                      input logic gr, input logic mw, input logic [4:0] dest,
                                      input logic [31:0] rkd, input logic [31:0] pc);
    return {dop, dest, 1'b0, mw, gr, op, rkd, s2, s1, pc};
  endfunction

  function automatic logic [11:0] onehot(input int idx);
    logic [11:0] one;
    one = 12'd1;
    return one << idx;
  endfunction

  // Single-cycle ALU instruction: expect it on the MEM bus right after entry
  task automatic run_alu(input string tag, input int op, input logic [31:0] s1,
                         input logic [31:0] s2, input logic [31:0] exp);
    bus_if.ds_to_es_bus   = mk(onehot(op), s1, s2, DIV_NONE, 1'b1, 1'b0, 5'd3, 32'd0, 32'h1c00_0100);
    bus_if.ds_to_es_valid = 1'b1;
    step();
    bus_if.ds_to_es_valid = 1'b0;
    chk({tag, "_valid"}, 32'(bus_if.es_to_ms_valid), 32'd1);
    chk(tag, bus_if.es_to_ms_bus[70:39], exp);
    $display("txn %s: src1=%h src2=%h result=%h", tag, s1, s2, bus_if.es_to_ms_bus[70:39]);
  endtask

  // Divide instruction: count cycles from presentation to es_to_ms_valid
  task automatic run_div(input string tag, input logic [1:0] dop, input logic [31:0] s1,
                         input logic [31:0] s2, input logic [31:0] exp);
    int n;
    bus_if.ds_to_es_bus   = mk(onehot(ALU_ADD), s1, s2, dop, 1'b1, 1'b0, 5'd7, 32'd0, 32'h1c00_0200);
    bus_if.ds_to_es_valid = 1'b1;
    step();
    bus_if.ds_to_es_valid = 1'b0;
    n = 1;
    while (bus_if.es_to_ms_valid !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    chk({tag, "_latency"}, 32'(n), 32'd34);
    chk(tag, bus_if.es_to_ms_bus[70:39], exp);
    $display("txn %s: src1=%h src2=%h result=%h latency=%0d", tag, s1, s2,
             bus_if.es_to_ms_bus[70:39], n);
    step();
    chk({tag, "_retired"}, 32'(bus_if.es_to_ms_valid), 32'd0);
  endtask

  initial begin
    int en_cnt;
    resetn                = 1'b0;
    bus_if.ds_to_es_valid = 1'b0;
    bus_if.ds_to_es_bus   = '0;
    bus_if.ms_allow_in    = 1'b1;

    // Reset state
    repeat (3) step();
    chk("rst_to_ms_valid", 32'(bus_if.es_to_ms_valid), 32'd0);
    chk("rst_allow_in",    32'(bus_if.es_allow_in),    32'd1);
    chk("rst_sram_en",     32'(bus_if.data_sram_en),   32'd0);
    chk("rst_sram_we",     32'(bus_if.data_sram_we),   32'd0);
    chk("rst_to_ds_bus",   32'(bus_if.es_to_ds_bus),   32'd0);
    $display("txn reset: outputs idle");
    resetn = 1'b1;
    step();

    // Overflowing add, plus forwarding/hazard fields
    run_alu("add_ovf", ALU_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000);
    chk("add_to_ds_bus", 32'(bus_if.es_to_ds_bus), 32'h23);
    chk("add_pc",        bus_if.es_to_ms_bus[31:0], 32'h1c00_0100);
    chk("add_gr_we",     32'(bus_if.es_to_ms_bus[32]), 32'd1);
    chk("add_dest",      32'(bus_if.es_to_ms_bus[38:34]), 32'd3);
    chk("add_sram_en",   32'(bus_if.data_sram_en), 32'd0);

    // Remaining ALU ops on one operand pair
    run_alu("sub",  ALU_SUB,  32'hF000_0010, 32'h0000_0004, 32'hF000_000C);
    run_alu("slt",  ALU_SLT,  32'hF000_0010, 32'h0000_0004, 32'h0000_0001);
    run_alu("sltu", ALU_SLTU, 32'hF000_0010, 32'h0000_0004, 32'h0000_0000);
    run_alu("and",  ALU_AND,  32'hF000_0010, 32'h0000_0004, 32'h0000_0000);
    run_alu("nor",  ALU_NOR,  32'hF000_0010, 32'h0000_0004, 32'h0FFF_FFEB);
    run_alu("or",   ALU_OR,   32'hF000_0010, 32'h0000_0004, 32'hF000_0014);
    run_alu("xor",  ALU_XOR,  32'hF000_0010, 32'h0000_0004, 32'hF000_0014);
    run_alu("sll",  ALU_SLL,  32'hF000_0010, 32'h0000_0004, 32'h0000_0100);
    run_alu("srl",  ALU_SRL,  32'hF000_0010, 32'h0000_0004, 32'h0F00_0001);
    run_alu("sra",  ALU_SRA,  32'hF000_0010, 32'h0000_0024, 32'hFF00_0001);
    run_alu("lui",  ALU_LUI,  32'hF000_0010, 32'h1234_5000, 32'h1234_5000);
    run_alu("slt_pos", ALU_SLT, 32'h0000_0004, 32'hF000_0010, 32'h0000_0000);
    step();

    // Divider results, sign fix-ups, divide by zero, overflow case
    run_div("div_q_m7_2",   DIV_SQ, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    run_div("div_r_m7_2",   DIV_SR, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
    run_div("div_uq_5_0",   DIV_UQ, 32'd5, 32'd0, 32'hFFFF_FFFF);
    run_div("div_r_5_0",    DIV_SR, 32'd5, 32'd0, 32'd5);
    run_div("div_q_min_m1", DIV_SQ, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    run_div("div_r_min_m1", DIV_SR, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
    run_div("div_uq_big",   DIV_UQ, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC);

    // Store under 3 cycles of MEM backpressure
    bus_if.ms_allow_in    = 1'b0;
    bus_if.ds_to_es_bus   = mk(onehot(ALU_ADD), 32'h0000_1000, 32'd0, DIV_NONE, 1'b0, 1'b1,
                               5'd0, 32'hDEAD_BEEF, 32'h1c00_0300);
    bus_if.ds_to_es_valid = 1'b1;
    step();
    bus_if.ds_to_es_valid = 1'b0;
    en_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      en_cnt += int'(bus_if.data_sram_en);
      chk("st_hold_en",    32'(bus_if.data_sram_en),   32'd0);
      chk("st_hold_valid", 32'(bus_if.es_to_ms_valid), 32'd1);
      chk("st_hold_addr",  bus_if.data_sram_addr,      32'h0000_1000);
      chk("st_hold_wdata", bus_if.data_sram_wdata,     32'hDEAD_BEEF);
      chk("st_hold_pc",    bus_if.es_to_ms_bus[31:0],  32'h1c00_0300);
      step();
    end
    bus_if.ms_allow_in = 1'b1;
    #1;
    en_cnt += int'(bus_if.data_sram_en);
    chk("st_en",   32'(bus_if.data_sram_en), 32'd1);
    chk("st_we",   32'(bus_if.data_sram_we), 32'hF);
    chk("st_addr", bus_if.data_sram_addr,    32'h0000_1000);
    step();
    en_cnt += int'(bus_if.data_sram_en);
    chk("st_en_after", 32'(bus_if.data_sram_en), 32'd0);
    chk("st_en_count", 32'(en_cnt), 32'd1);
    $display("txn store: addr=00001000 wdata=deadbeef requests=%0d", en_cnt);

    // Reset during BUSY, then a clean divide
    bus_if.ds_to_es_bus   = mk(onehot(ALU_ADD), 32'd1000, 32'd3, DIV_SQ, 1'b1, 1'b0, 5'd7,
                               32'd0, 32'h1c00_0400);
    bus_if.ds_to_es_valid = 1'b1;
    step();
    bus_if.ds_to_es_valid = 1'b0;
    repeat (11) step();
    chk("mid_to_ds_bus", 32'(bus_if.es_to_ds_bus), 32'h27);
    chk("mid_allow_in",  32'(bus_if.es_allow_in),  32'd0);
    resetn = 1'b0;
    #1;
    chk("arst_allow_in",    32'(bus_if.es_allow_in),    32'd1);
    chk("arst_to_ms_valid", 32'(bus_if.es_to_ms_valid), 32'd0);
    chk("arst_to_ds_bus",   32'(bus_if.es_to_ds_bus),   32'd0);
    chk("arst_sram_en",     32'(bus_if.data_sram_en),   32'd0);
    $display("txn async reset during divide");
    step();
    step();
    resetn = 1'b1;
    step();
    run_div("div_q_100_7", DIV_SQ, 32'd100, 32'd7, 32'd14);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
